// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register plus the EX-stage operand network (forwarding, shamt/imm select)
// feeding the ALU, with load-use hazard detection toward IF/ID.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int FUN_W  = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [FUN_W-1:0]  id_alufun,
  input  logic              id_sign,
  input  logic              id_alusrc1,
  input  logic              id_alusrc2,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              flush,
  input  logic              hold,
  input  logic              exmem_wr,
  input  logic [RA_W-1:0]   exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_wr,
  input  logic [RA_W-1:0]   memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FUN_W-1:0]  alu_fun,
  output logic              alu_sign,
  output logic              ex_valid,
  output logic [RA_W-1:0]   ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              stall_req
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   rd;
    logic [DATA_W-1:0] imm;
    logic [4:0]        shamt;
    logic [FUN_W-1:0]  alufun;
    logic              sign;
    logic              alusrc1;
    logic              alusrc2;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
  } ex_reg_t;

  ex_reg_t ex_q, ex_d, id_cap;
  logic    lu;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  // A bubble in EX has memread=0, so it can never raise a load-use stall.
  assign lu = ex_q.valid & ex_q.memread & (ex_q.rd != '0) & id_valid &
              ((id_use_rs & (id_rs == ex_q.rd)) | (id_use_rt & (id_rt == ex_q.rd)));
  assign stall_req = lu | hold;

  always_comb begin
    // NOTE: every always_comb target gets a full default first so no path can infer a latch.
    id_cap          = '0;
    id_cap.valid    = id_valid;
    id_cap.rs_data  = id_rs_data;
    id_cap.rt_data  = id_rt_data;
    id_cap.rs       = id_rs;
    id_cap.rt       = id_rt;
    id_cap.rd       = id_rd;
    id_cap.imm      = id_imm;
    id_cap.shamt    = id_shamt;
    id_cap.alufun   = id_alufun;
    id_cap.sign     = id_sign;
    id_cap.alusrc1  = id_alusrc1;
    id_cap.alusrc2  = id_alusrc2;
    id_cap.regwrite = id_regwrite & id_valid;
    id_cap.memread  = id_memread  & id_valid;
    id_cap.memwrite = id_memwrite & id_valid;

    ex_d = ex_q;
    // Flush outranks hold; a bubble keeps stale data fields, only valid/control are cleared.
    if (flush || (!hold && lu)) begin
      ex_d.valid    = 1'b0;
      ex_d.regwrite = 1'b0;
      ex_d.memread  = 1'b0;
      ex_d.memwrite = 1'b0;
    end else if (!hold) begin
      ex_d = id_cap;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) ex_q <= '0;
    else          ex_q <= ex_d;
  end

  function automatic logic [DATA_W-1:0] fwd(
    input logic [RA_W-1:0]   src,
    input logic [DATA_W-1:0] rf,
    input logic              e_wr,
    input logic [RA_W-1:0]   e_rd,
    input logic [DATA_W-1:0] e_data,
    input logic              m_wr,
    input logic [RA_W-1:0]   m_rd,
    input logic [DATA_W-1:0] m_data
  );
    if (src == '0)                 return '0;
    else if (e_wr && e_rd == src)  return e_data;
    else if (m_wr && m_rd == src)  return m_data;
    else                           return rf;
  endfunction

  assign fwd_rs = fwd(ex_q.rs, ex_q.rs_data, exmem_wr, exmem_rd, exmem_data,
                      memwb_wr, memwb_rd, memwb_data);
  assign fwd_rt = fwd(ex_q.rt, ex_q.rt_data, exmem_wr, exmem_rd, exmem_data,
                      memwb_wr, memwb_rd, memwb_data);

  assign alu_a         = ex_q.alusrc1 ? {{(DATA_W-5){1'b0}}, ex_q.shamt} : fwd_rs;
  assign alu_b         = ex_q.alusrc2 ? ex_q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_fun       = ex_q.alufun;
  assign alu_sign      = ex_q.sign;
  assign ex_valid      = ex_q.valid;
  assign ex_rd         = ex_q.rd;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;

endmodule
